// File: rtl/flag_unit_pkg.sv
// flag_unit_pkg: register ids, flag-set layout and branch codes shared
// between the flag unit and the decode-stage branch evaluator.
package flag_unit_pkg;

    // Register select encoding used by ex_dest, wb_dest and br_reg
    localparam logic REG_A = 1'b0;
    localparam logic REG_B = 1'b1;

    // Bit positions inside a 3-bit flag set, ordered {Z,N,C}
    localparam int FLAG_Z = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 0;

    typedef logic [2:0] flags_t;

    // Branch condition codes understood by the branch evaluator
    typedef enum logic [2:0] {
        BR_ZS = 3'd0,
        BR_ZC = 3'd1,
        BR_NS = 3'd2,
        BR_NC = 3'd3,
        BR_CS = 3'd4,
        BR_CC = 3'd5,
        BR_AL = 3'd6,
        BR_NV = 3'd7
    } br_code_e;

    // Build a flag set from a result's zero/sign tests and its carry
    function automatic flags_t make_flags(
        input logic is_zero,
        input logic is_neg,
        input logic carry
    );
        flags_t f;
        f         = '0;
        f[FLAG_Z] = is_zero;
        f[FLAG_N] = is_neg;
        f[FLAG_C] = carry;
        return f;
    endfunction

    // Condition test shared with the branch evaluator
    function automatic logic br_taken(
        input br_code_e code,
        input flags_t   f
    );
        logic t;
        t = 1'b0;
        unique case (code)
            BR_ZS:   t = f[FLAG_Z];
            BR_ZC:   t = ~f[FLAG_Z];
            BR_NS:   t = f[FLAG_N];
            BR_NC:   t = ~f[FLAG_N];
            BR_CS:   t = f[FLAG_C];
            BR_CC:   t = ~f[FLAG_C];
            BR_AL:   t = 1'b1;
            BR_NV:   t = 1'b0;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/flag_unit_pend_counter.sv
// flag_unit_pend_counter (pend_counter): saturating count of in-flight
// flag-writing ops for one register, with over/underflow pulses.
module flag_unit_pend_counter #(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          unf
);

    localparam logic [CW-1:0] MAX = CW'(DEPTH);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: issue and retire in the same cycle cancel out;
    // an issue at MAX or a retire at zero holds and reports the fault.
    always_comb begin
        cnt_d = cnt_q;
        ovf   = 1'b0;
        unf   = 1'b0;
        if (inc && !dec) begin
            if (cnt_q == MAX) begin
                ovf = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (dec && !inc) begin
            if (cnt_q == '0) begin
                unf = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    // Counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/flag_unit.sv
// flag_unit: Z/N/C flag registers for A and B plus branch stall logic.
// Define FLAG_FWD_EN to bypass WB flags to the outputs in the WB cycle.
module flag_unit
    import flag_unit_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PIPE_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ex_issue,
    input  logic              ex_dest,
    input  logic              wb_valid,
    input  logic              wb_dest,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              wb_carry,
    input  logic              br_valid,
    input  logic              br_reg,
    output logic              br_stall,
    output logic              ZA,
    output logic              NA,
    output logic              CA,
    output logic              ZB,
    output logic              NB,
    output logic              CB,
    output logic              err
);

    localparam int CW = $clog2(PIPE_DEPTH + 1);

    logic          iss_a;
    logic          iss_b;
    logic          wb_a;
    logic          wb_b;
    logic [CW-1:0] pend_a;
    logic [CW-1:0] pend_b;
    logic          ovf_a;
    logic          unf_a;
    logic          ovf_b;
    logic          unf_b;

    flags_t        wb_flags;
    flags_t        flags_a_q;
    flags_t        flags_a_d;
    flags_t        flags_b_q;
    flags_t        flags_b_d;
    flags_t        out_a;
    flags_t        out_b;
    logic          err_q;
    logic          err_d;

    logic [CW-1:0] pend_sel;
    logic          wb_sel;
    logic          busy;

    // Decode issue and write-back strobes per register
    always_comb begin
        iss_a = ex_issue && (ex_dest == REG_A);
        iss_b = ex_issue && (ex_dest == REG_B);
        wb_a  = wb_valid && (wb_dest == REG_A);
        wb_b  = wb_valid && (wb_dest == REG_B);
    end

    flag_unit_pend_counter #(
        .DEPTH (PIPE_DEPTH),
        .CW    (CW)
    ) u_pend_a (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (iss_a),
        .dec   (wb_a),
        .count (pend_a),
        .ovf   (ovf_a),
        .unf   (unf_a)
    );

    flag_unit_pend_counter #(
        .DEPTH (PIPE_DEPTH),
        .CW    (CW)
    ) u_pend_b (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (iss_b),
        .dec   (wb_b),
        .count (pend_b),
        .ovf   (ovf_b),
        .unf   (unf_b)
    );

    // Flags produced by the op completing WB this cycle
    always_comb begin
        wb_flags = make_flags(
            wb_result == '0,
            wb_result[DATA_W-1],
            wb_carry
        );
    end

    // Next flag state: only the WB target set is overwritten;
    // the error bit latches any counter fault until reset.
    always_comb begin
        flags_a_d = flags_a_q;
        flags_b_d = flags_b_q;
        if (wb_a) begin
            flags_a_d = wb_flags;
        end
        if (wb_b) begin
            flags_b_d = wb_flags;
        end
        err_d = err_q | ovf_a | unf_a | ovf_b | unf_b;
    end

    // Flag and error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flags_a_q <= '0;
            flags_b_q <= '0;
            err_q     <= 1'b0;
        end else begin
            flags_a_q <= flags_a_d;
            flags_b_q <= flags_b_d;
            err_q     <= err_d;
        end
    end

    // Output flag sets, optionally bypassing the WB result
    always_comb begin
        out_a = flags_a_q;
        out_b = flags_b_q;
`ifdef FLAG_FWD_EN
        if (wb_a) begin
            out_a = wb_flags;
        end
        if (wb_b) begin
            out_b = wb_flags;
        end
`endif
    end

    // Stall a branch while its register still has unfinished writers
    always_comb begin
        pend_sel = (br_reg == REG_B) ? pend_b : pend_a;
        wb_sel   = (br_reg == REG_B) ? wb_b : wb_a;
`ifdef FLAG_FWD_EN
        // The op in WB counts as done; a retire at zero stays at zero
        busy = (pend_sel > CW'(1))
            || ((pend_sel == CW'(1)) && !wb_sel);
`else
        // The op in WB is not visible until its flags are registered
        busy = (pend_sel != '0) || wb_sel;
`endif
        br_stall = br_valid && busy;
    end

    assign ZA  = out_a[FLAG_Z];
    assign NA  = out_a[FLAG_N];
    assign CA  = out_a[FLAG_C];
    assign ZB  = out_b[FLAG_Z];
    assign NB  = out_b[FLAG_N];
    assign CB  = out_b[FLAG_C];
    assign err = err_q;

endmodule

// File: tb/tb_flag_unit.sv
// tb_flag_unit: directed and random checks of flag_unit against a
// behavioural model of the in-flight counts and flag sets.
module tb_flag_unit;

    localparam int DATA_W     = 8;
    localparam int PIPE_DEPTH = 2;

`ifdef FLAG_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              ex_issue;
    logic              ex_dest;
    logic              wb_valid;
    logic              wb_dest;
    logic [DATA_W-1:0] wb_result;
    logic              wb_carry;
    logic              br_valid;
    logic              br_reg;
    logic              br_stall;
    logic              ZA, NA, CA, ZB, NB, CB;
    logic              err;

    int checks;
    int errors;

    // Model state: outstanding ops and last written flags per register
    int          m_pend [2];
    logic [2:0]  m_flags[2];
    logic        m_err;

    flag_unit #(
        .DATA_W     (DATA_W),
        .PIPE_DEPTH (PIPE_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ex_issue  (ex_issue),
        .ex_dest   (ex_dest),
        .wb_valid  (wb_valid),
        .wb_dest   (wb_dest),
        .wb_result (wb_result),
        .wb_carry  (wb_carry),
        .br_valid  (br_valid),
        .br_reg    (br_reg),
        .br_stall  (br_stall),
        .ZA        (ZA),
        .NA        (NA),
        .CA        (CA),
        .ZB        (ZB),
        .NB        (NB),
        .CB        (CB),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] calc(input logic [7:0] r, input logic c);
        return {(r == 8'h00), r[7], c};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic iss, input logic idst,
                         input logic wbv, input logic wbd,
                         input logic [7:0] res, input logic car,
                         input logic brv, input logic brr);
        ex_issue  = iss;
        ex_dest   = idst;
        wb_valid  = wbv;
        wb_dest   = wbd;
        wb_result = res;
        wb_carry  = car;
        br_valid  = brv;
        br_reg    = brr;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 8'h00, 0, 0, 0);
    endtask

    // Compare all outputs with what the model predicts for current inputs
    task automatic check_all(input string tag);
        logic [2:0] fa;
        logic [2:0] fb;
        int         eff;
        int         wbx;
        fa  = m_flags[0];
        fb  = m_flags[1];
        if (FWD && wb_valid) begin
            if (wb_dest) fb = calc(wb_result, wb_carry);
            else         fa = calc(wb_result, wb_carry);
        end
        wbx = (wb_valid && wb_dest == br_reg) ? 1 : 0;
        if (FWD) begin
            eff = m_pend[int'(br_reg)] - wbx;
            if (eff < 0) eff = 0;
        end else begin
            eff = m_pend[int'(br_reg)] + wbx;
        end
        chk({tag, "_flags"}, {2'b00, ZA, NA, CA, ZB, NB, CB},
            {2'b00, fa, fb});
        chk({tag, "_stall"}, {7'd0, br_stall},
            {7'd0, br_valid && (eff != 0)});
        chk({tag, "_err"}, {7'd0, err}, {7'd0, m_err});
    endtask

    task automatic model_clock();
        for (int x = 0; x < 2; x++) begin
            bit inc;
            bit dec;
            inc = ex_issue && (ex_dest == x[0]);
            dec = wb_valid && (wb_dest == x[0]);
            if (inc && !dec) begin
                if (m_pend[x] == PIPE_DEPTH) m_err = 1'b1;
                else m_pend[x]++;
            end else if (dec && !inc) begin
                if (m_pend[x] == 0) m_err = 1'b1;
                else m_pend[x]--;
            end
        end
        if (wb_valid) m_flags[int'(wb_dest)] = calc(wb_result, wb_carry);
    endtask

    task automatic model_reset();
        m_pend[0]  = 0;
        m_pend[1]  = 0;
        m_flags[0] = 3'b000;
        m_flags[1] = 3'b000;
        m_err      = 1'b0;
    endtask

    // One clock with the currently driven inputs; returns at edge + 1
    task automatic cycle(input string tag);
        #2;
        check_all(tag);
        @(posedge clk);
        model_clock();
        #1;
    endtask

    // Asynchronous reset applied between edges, checked while held
    task automatic do_reset();
        drive(0, 0, 0, 0, 8'h00, 0, 1, 0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_flags", {2'b00, ZA, NA, CA, ZB, NB, CB}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);
        chk("rst_stall", {7'd0, br_stall}, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        idle();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // Reset mid-stream with two A ops in flight
        drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
        cycle("iss_a0");
        cycle("iss_a1");
        drive(0, 0, 0, 0, 8'h00, 0, 1, 0);
        #1;
        chk("pend2_stall", {7'd0, br_stall}, 8'h01);
        do_reset();

        // WB to A: zero result with carry
        drive(0, 0, 1, 0, 8'h00, 1, 0, 0);
        cycle("wb_a");
        idle();
        #1;
        chk("wb_a_fa", {5'd0, ZA, NA, CA}, 8'h05);
        chk("wb_a_fb", {5'd0, ZB, NB, CB}, 8'h00);

        // WB to B: negative result without carry
        drive(0, 0, 1, 1, 8'h80, 0, 0, 0);
        cycle("wb_b");
        idle();
        #1;
        chk("wb_b_fb", {5'd0, ZB, NB, CB}, 8'h02);
        chk("wb_b_fa", {5'd0, ZA, NA, CA}, 8'h05);
        do_reset();

        // Branch on A around its producer's WB
        drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
        cycle("bt_c0");
        drive(0, 0, 0, 0, 8'h00, 0, 1, 0);
        #1;
        chk("bt_c1_stall", {7'd0, br_stall}, 8'h01);
        cycle("bt_c1");
        drive(0, 0, 1, 0, 8'h00, 0, 1, 0);
        #1;
        chk("bt_c2_stall", {7'd0, br_stall}, FWD ? 8'h00 : 8'h01);
        chk("bt_c2_za", {7'd0, ZA}, FWD ? 8'h01 : 8'h00);
        cycle("bt_c2");
        drive(0, 0, 0, 0, 8'h00, 0, 1, 0);
        #1;
        chk("bt_c3_stall", {7'd0, br_stall}, 8'h00);
        chk("bt_c3_za", {7'd0, ZA}, 8'h01);
        cycle("bt_c3");
        do_reset();

        // Same-cycle issue and WB to A with one op in flight
        drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
        cycle("sc_c0");
        drive(1, 0, 1, 0, 8'h05, 0, 1, 0);
        #1;
        chk("sc_stall_a", {7'd0, br_stall}, FWD ? 8'h00 : 8'h01);
        br_reg = 1'b1;
        #1;
        chk("sc_stall_b", {7'd0, br_stall}, 8'h00);
        br_reg = 1'b0;
        cycle("sc_c1");
        drive(0, 0, 0, 0, 8'h00, 0, 1, 0);
        #1;
        chk("sc_hold_a", {7'd0, br_stall}, 8'h01);
        chk("sc_err", {7'd0, err}, 8'h00);
        cycle("sc_c2");
        do_reset();

        // Overflow: three issues to A without a WB
        drive(1, 0, 0, 0, 8'h00, 0, 0, 0);
        cycle("ov_c0");
        cycle("ov_c1");
        chk("ov_err_before", {7'd0, err}, 8'h00);
        cycle("ov_c2");
        idle();
        #1;
        chk("ov_err_after", {7'd0, err}, 8'h01);
        do_reset();

        // Underflow: WB to B with nothing in flight
        drive(0, 0, 1, 1, 8'h7F, 1, 0, 0);
        cycle("uf_c0");
        idle();
        #1;
        chk("uf_err", {7'd0, err}, 8'h01);
        chk("uf_fb", {5'd0, ZB, NB, CB}, 8'h01);
        cycle("uf_c1");
        chk("uf_sticky", {7'd0, err}, 8'h01);
        do_reset();

        // Random traffic, occasional mid-stream reset
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 2) == 0,
                      1'($urandom_range(0, 1)),
                      $urandom_range(0, 2) == 0,
                      1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? 8'h00
                                                  : 8'($urandom),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)));
                cycle("rnd");
            end
        end

        idle();
        #2;
        check_all("end");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/flag_unit.md
# flag_unit

Status-flag producer for the accumulator pipeline: computes and holds zero/negative/carry flags for registers A and B from ALU write-back results and drives them (ZA, NA, CA, ZB, NB, CB) into the branch condition evaluator. Tracks in-flight flag-writing ALU ops per register and stalls a decode-stage branch whose source flags are not yet final. Sits between the WB stage and the decode-stage branch logic.

## Interface
- DATA_W, 8, width of ALU result
- PIPE_DEPTH, 2, max flag-writing ops in flight per register (EX..WB)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- ex_issue  in  1  flag-writing ALU op enters EX this cycle
- ex_dest  in  1  register targeted by ex_issue (0=A, 1=B)
- wb_valid  in  1  flag-writing op completes WB this cycle
- wb_dest  in  1  register targeted by wb_valid (0=A, 1=B)
- wb_result  in  DATA_W  ALU result at WB
- wb_carry  in  1  ALU carry-out at WB
- br_valid  in  1  branch in decode requesting flags
- br_reg  in  1  register whose flags the branch tests (0=A, 1=B)
- br_stall  out  1  branch must hold in decode this cycle
- ZA, NA, CA  out  1 each  flags of register A
- ZB, NB, CB  out  1 each  flags of register B
- err  out  1  sticky scoreboard over/underflow

## Operation
- Flag computation on wb_valid: Z = (wb_result == 0), N = wb_result[DATA_W-1], C = wb_carry; written to the wb_dest flag set only; other set unchanged.
- Per-register pending counter pend_A/pend_B, width clog2(PIPE_DEPTH+1):
  - ex_issue to reg X only: pend_X + 1.
  - wb_valid to reg X only: pend_X - 1.
  - both to same reg X same cycle: pend_X unchanged.
  - issue and WB to different regs: each counter moves independently.
- Boundaries:
  - issue with pend_X == PIPE_DEPTH (and no same-cycle WB to X): counter holds, err set.
  - WB with pend_X == 0 (and no same-cycle issue to X): flags still written, counter holds at 0, err set.
  - err clears only on reset.
- br_stall = br_valid && (effective pending of br_reg != 0); br_valid low forces br_stall low.
- Effective pending: see Configuration.
- Reset mid-operation: all counters, flags, err return to 0 immediately; in-flight ops are forgotten.

## Timing
- Reset values: ZA=NA=CA=ZB=NB=CB=0, err=0, br_stall=0 (given br_valid=0), counters 0.
- Flag registers and counters update on rising clk; flag outputs reflect a WB one cycle after wb_valid (without bypass).
- br_stall is combinational from br_valid/br_reg and current state; no registered latency.
- Branch issued one cycle after its producer's WB cycle sees final flags with no stall in either configuration.

## Configuration
- FLAG_FWD_EN defined: WB bypass. Flag outputs for wb_dest combinationally show the newly computed flags during the wb_valid cycle; effective pending = pend_X minus 1 if wb_valid to X this cycle, so a branch is released in the WB cycle when that is the last outstanding op.
- FLAG_FWD_EN undefined: outputs come from flag registers only; effective pending = pend_X, plus 1 if wb_valid to X this cycle (branch stalls through the WB cycle, released next cycle).

## Structure
- Shared include (flag_defs): REG_A=0, REG_B=1 constants, flag-set bit ordering {Z,N,C}, branch-code constants shared with the branch evaluator.
- One sub-module, pend_counter: saturating up/down counter with over/underflow flag, instantiated once per register.
- Top level holds the two 3-bit flag registers, flag computation, bypass muxes, stall logic.

## Test plan
- Reset: assert rst_n=0 mid-stream with pend_A=2 -> all flags 0, err 0, br_stall 0 for br_valid=1.
- WB to A with wb_result=8'h00, wb_carry=1 -> next cycle ZA=1, NA=0, CA=1; B flags unchanged.
- WB to B with wb_result=8'h80, wb_carry=0 -> ZB=0, NB=1, CB=0.
- ex_issue A at cycle 0, br_valid A/br_reg=0 at cycles 1..3, WB A at cycle 2 -> br_stall 1,1(WB cycle, no FWD)/0(with FLAG_FWD_EN),0; ZA visible in WB cycle only with FLAG_FWD_EN.
- Same-cycle ex_issue A and wb_valid A with pend_A=1 -> pend_A stays 1, branch on A still stalls; branch on B not stalled.
- Three ex_issue to A without WB (PIPE_DEPTH=2) -> err=1 after third; WB with pend_B=0 -> err=1, flags written.
